comb_filter: RTL

Feedback comb filter with a damping low-pass in the loop, per Schroeder/Freeverb. It is the stage directly upstream of the all-pass diffusers in the reverb chain. A bank of these runs in parallel, and their summed outputs feed the all-pass cascade. The block owns its circular delay RAM and processes one sample per in_valid strobe on the system clock.

---
 rtl/comb_filter_if.sv | 33 +++
 rtl/comb_filter.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/comb_filter_if.sv
// comb_filter_if: sample/config/result bundle for one comb_filter instance.
//   master (driver side) : in_valid, in, tau, gain, damp, write
//   slave  (filter side) : ready, out_valid, out, overrun, state_dbg
// Handshake: a sample is accepted on any clock edge where in_valid && ready.
// in_valid while !ready is not held off; the sample is dropped and overrun
// goes sticky. out_valid is a one-cycle strobe with out valid in that cycle.
// write is a one-cycle strobe and needs no ready. state_dbg mirrors the FSM.
interface comb_filter_if #(
  parameter int W  = 32,
  parameter int AW = 12
);
  logic          in_valid;
  logic [W-1:0]  in;
  logic [AW-1:0] tau;
  logic [W-1:0]  gain;
  logic [W-1:0]  damp;
  logic          write;
  logic          ready;
  logic          out_valid;
  logic [W-1:0]  out;
  logic          overrun;
  logic [2:0]    state_dbg;

  modport master (
    output in_valid, in, tau, gain, damp, write,
    input  ready, out_valid, out, overrun, state_dbg
  );

  modport slave (
    input  in_valid, in, tau, gain, damp, write,
    output ready, out_valid, out, overrun, state_dbg
  );
endinterface

// File: rtl/comb_filter.sv
// comb_filter: Freeverb-style feedback comb with a one-pole damping low-pass
// in the loop. Owns a MAXLEN-deep circular delay RAM; one sample per accepted
// in_valid, 4 cycles per sample (IDLE, READ, FILTER, WRITE).
// Ports:
//   clk, rst : system clock, synchronous active-high reset
//   bus      : comb_filter_if slave (sample in, config, result, overrun, state_dbg)
module comb_filter #(
  parameter int WIDTH  = 24,
  parameter int FRAC   = 8,
  parameter int MAXLEN = 4096
) (
  input  logic         clk,
  input  logic         rst,
  comb_filter_if.slave bus
);
  localparam int W  = WIDTH + FRAC;
  localparam int AW = $clog2(MAXLEN);
  localparam logic signed [W-1:0] ONE_W = W'(2 ** FRAC);
  localparam logic signed [W-1:0] SMAX  = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] SMIN  = {1'b1, {(W-1){1'b0}}};
  localparam logic [AW-1:0] LAST_ADDR   = AW'(MAXLEN - 1);

  typedef enum logic [2:0] {
    S_CLEAR  = 3'd0,
    S_IDLE   = 3'd1,
    S_READ   = 3'd2,
    S_FILTER = 3'd3,
    S_WRITE  = 3'd4
  } state_t;

  function automatic logic signed [W-1:0] sat(input logic signed [2*W:0] v);
    if (v > (2*W+1)'(SMAX))      return SMAX;
    else if (v < (2*W+1)'(SMIN)) return SMIN;
    else                         return v[W-1:0];
  endfunction

  state_t                 state_q, state_d;
  logic [AW-1:0]          clr_ptr_q, clr_ptr_d;
  logic [AW-1:0]          wr_ptr_q, wr_ptr_d;
  logic signed [W-1:0]    x_in_q, x_in_d;
  logic signed [W-1:0]    x_del_q, x_del_d;
  logic signed [W-1:0]    lp_q, lp_d;
  logic [W-1:0]           out_q, out_d;
  logic                   out_valid_q, out_valid_d;
  logic                   overrun_q, overrun_d;
  logic [AW-1:0]          t_q, t_d;
  logic signed [W-1:0]    g_q, g_d;
  logic signed [W-1:0]    d_q, d_d;
  logic                   pend_valid_q, pend_valid_d;
  logic [AW-1:0]          pend_t_q, pend_t_d;
  logic [W-1:0]           pend_g_q, pend_g_d;
  logic [W-1:0]           pend_d_q, pend_d_d;

  // Delay RAM: synchronous read, one write port. Not reset; CLEAR zeroes it.
  logic [W-1:0]  mem [MAXLEN];
  logic [W-1:0]  ram_rdata;
  logic          ram_we;
  logic [AW-1:0] ram_waddr;
  logic [W-1:0]  ram_wdata;
  logic [AW-1:0] ram_raddr;

  // Datapath
  logic signed [W-1:0]     coef_x;
  logic signed [2*W-1:0]   p_x, p_lp, p_fb;
  logic signed [2*W:0]     lp_sum;
  logic signed [W-1:0]     lp_new;
  logic signed [W-1:0]     fb;
  logic signed [W:0]       wr_sum;
  logic [AW-1:0]           tau_cl;

  always_comb begin
    coef_x = ONE_W - d_q;
    p_x    = (2*W)'(coef_x) * (2*W)'(x_del_q);
    p_lp   = (2*W)'(d_q) * (2*W)'(lp_q);
    lp_sum = ((2*W+1)'(p_x) + (2*W+1)'(p_lp)) >>> FRAC;
    lp_new = sat(lp_sum);
    // Feedback term is clamped to a word first so the final sum fits W+1 bits.
    p_fb   = (2*W)'(g_q) * (2*W)'(lp_q);
    fb     = sat((2*W+1)'(p_fb >>> FRAC));
    wr_sum = (W+1)'(x_in_q) + (W+1)'(fb);
    tau_cl = (bus.tau == '0) ? AW'(1) : bus.tau;
  end

  always_comb begin
    state_d      = state_q;
    clr_ptr_d    = clr_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    x_in_d       = x_in_q;
    x_del_d      = x_del_q;
    lp_d         = lp_q;
    out_d        = out_q;
    out_valid_d  = 1'b0;
    overrun_d    = overrun_q;
    t_d          = t_q;
    g_d          = g_q;
    d_d          = d_q;
    pend_valid_d = pend_valid_q;
    pend_t_d     = pend_t_q;
    pend_g_d     = pend_g_q;
    pend_d_d     = pend_d_q;
    ram_we       = 1'b0;
    ram_waddr    = wr_ptr_q;
    ram_wdata    = '0;
    ram_raddr    = wr_ptr_q - t_q;  // modulo MAXLEN by width

    if (bus.in_valid && state_q != S_IDLE) overrun_d = 1'b1;

    unique case (state_q)
      S_CLEAR: begin
        ram_we    = 1'b1;
        ram_waddr = clr_ptr_q;
        clr_ptr_d = clr_ptr_q + AW'(1);
        if (clr_ptr_q == LAST_ADDR) state_d = S_IDLE;
      end
      S_IDLE: begin
        if (bus.in_valid) begin
          x_in_d  = bus.in;
          state_d = S_READ;
        end
      end
      S_READ: begin
        x_del_d = ram_rdata;
        state_d = S_FILTER;
      end
      S_FILTER: begin
        lp_d        = lp_new;
        // Registered here so out and out_valid appear together in WRITE.
        out_d       = x_del_q;
        out_valid_d = 1'b1;
        state_d     = S_WRITE;
      end
      S_WRITE: begin
        ram_we    = 1'b1;
        ram_wdata = sat((2*W+1)'(wr_sum));
        wr_ptr_d  = wr_ptr_q + AW'(1);
        state_d   = S_IDLE;
      end
      default: state_d = S_CLEAR;
    endcase

    // Config: apply directly only when no sample is in flight; otherwise park
    // it and apply on the WRITE->IDLE edge. A write landing in WRITE itself is
    // already at that edge, so it is applied directly.
    if (bus.write) begin
      if ((state_q == S_IDLE && !bus.in_valid) || state_q == S_WRITE) begin
        t_d          = tau_cl;
        g_d          = bus.gain;
        d_d          = bus.damp;
        pend_valid_d = 1'b0;
      end else begin
        pend_valid_d = 1'b1;
        pend_t_d     = tau_cl;
        pend_g_d     = bus.gain;
        pend_d_d     = bus.damp;
      end
    end else if (state_q == S_WRITE && pend_valid_q) begin
      t_d          = pend_t_q;
      g_d          = pend_g_q;
      d_d          = pend_d_q;
      pend_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we && !rst) mem[ram_waddr] <= ram_wdata;
    ram_rdata <= mem[ram_raddr];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_CLEAR;
      clr_ptr_q    <= '0;
      wr_ptr_q     <= '0;
      x_in_q       <= '0;
      x_del_q      <= '0;
      lp_q         <= '0;
      out_q        <= '0;
      out_valid_q  <= 1'b0;
      overrun_q    <= 1'b0;
      t_q          <= AW'(1);
      g_q          <= '0;
      d_q          <= '0;
      pend_valid_q <= 1'b0;
      pend_t_q     <= '0;
      pend_g_q     <= '0;
      pend_d_q     <= '0;
    end else begin
      state_q      <= state_d;
      clr_ptr_q    <= clr_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      x_in_q       <= x_in_d;
      x_del_q      <= x_del_d;
      lp_q         <= lp_d;
      out_q        <= out_d;
      out_valid_q  <= out_valid_d;
      overrun_q    <= overrun_d;
      t_q          <= t_d;
      g_q          <= g_d;
      d_q          <= d_d;
      pend_valid_q <= pend_valid_d;
      pend_t_q     <= pend_t_d;
      pend_g_q     <= pend_g_d;
      pend_d_q     <= pend_d_d;
    end
  end

  assign bus.ready     = (state_q == S_IDLE);
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.overrun   = overrun_q;
  assign bus.state_dbg = state_q;
endmodule
